// File: rtl/random_dir_gen.sv
`default_nettype none
// ============================================================================
// Module      : random_dir_gen
// Description : LFSR-driven one-hot direction picker with frame hold timer,
//               blocked-direction avoidance and forced re-pick.
// Revision    : 1.0 - initial release
// ============================================================================
module random_dir_gen #(
  parameter int                NUM_DIRS    = 4,
  parameter int                LFSR_W      = 8,
  parameter logic [LFSR_W-1:0] TAPS        = 8'hB8,
  parameter logic [LFSR_W-1:0] SEED        = 8'h01,
  parameter int                HOLD_FRAMES = 32
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                enable,
  input  logic                startOfFrame,
  input  logic [NUM_DIRS-1:0] blocked,
  input  logic                force_change,
  output logic [NUM_DIRS-1:0] random_direction,
  output logic                direction_valid,
  output logic                dir_changed
);

  localparam int c_IDX_W = $clog2(NUM_DIRS);
  localparam int c_CNT_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  // A zero seed would lock the LFSR at zero forever.
  localparam logic [LFSR_W-1:0] c_SEED_EFF =
    (SEED == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : SEED;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PICK  = 2'd1,
    S_HOLD  = 2'd2,
    S_STUCK = 2'd3
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [LFSR_W-1:0]    r_lfsr, w_lfsr_nxt;
  logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [NUM_DIRS-1:0]  r_dir, w_dir_nxt;
  logic                 r_valid, w_valid_nxt;
  logic                 r_chg, w_chg_nxt;

  logic [c_IDX_W-1:0]   w_cand;
  logic [c_IDX_W:0]     w_sum;
  logic [c_IDX_W-1:0]   w_sel;
  logic                 w_sel_ok;
  logic                 w_cur_blocked;

  always_comb begin
    w_lfsr_nxt = r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS) : (r_lfsr >> 1);
  end

  // Scan downward so the last hit written is the first free slot from w_cand.
  always_comb begin
    w_cand = r_lfsr[c_IDX_W-1:0];
    if ({1'b0, w_cand} >= (c_IDX_W+1)'(NUM_DIRS)) begin
      w_cand = w_cand - c_IDX_W'(NUM_DIRS);
    end
    w_sum    = '0;
    w_sel    = '0;
    w_sel_ok = 1'b0;
    for (int k = NUM_DIRS - 1; k >= 0; k--) begin
      w_sum = {1'b0, w_cand} + (c_IDX_W+1)'(k);
      if (w_sum >= (c_IDX_W+1)'(NUM_DIRS)) begin
        w_sum = w_sum - (c_IDX_W+1)'(NUM_DIRS);
      end
      if (!blocked[w_sum[c_IDX_W-1:0]]) begin
        w_sel    = w_sum[c_IDX_W-1:0];
        w_sel_ok = 1'b1;
      end
    end
  end

  assign w_cur_blocked = |(blocked & r_dir);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    w_valid_nxt = r_valid;
    w_chg_nxt   = 1'b0;
    if (!enable) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_dir_nxt   = '0;
      w_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_PICK;
        S_PICK: begin
          if (w_sel_ok) begin
            w_dir_nxt   = NUM_DIRS'(1) << w_sel;
            w_valid_nxt = 1'b1;
            w_chg_nxt   = 1'b1;
            w_cnt_nxt   = c_CNT_W'(HOLD_FRAMES - 1);
            w_state_nxt = S_HOLD;
          end else begin
            w_dir_nxt   = '0;
            w_valid_nxt = 1'b0;
            w_state_nxt = S_STUCK;
          end
        end
        S_HOLD: begin
          if (w_cur_blocked || force_change) begin
            w_state_nxt = S_PICK;
          end else if (startOfFrame) begin
            if (r_cnt == '0) w_state_nxt = S_PICK;
            else             w_cnt_nxt   = r_cnt - c_CNT_W'(1);
          end
        end
        S_STUCK: begin
          if (startOfFrame) w_state_nxt = S_PICK;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state <= S_IDLE;
      r_lfsr  <= c_SEED_EFF;
      r_cnt   <= '0;
      r_dir   <= '0;
      r_valid <= 1'b0;
      r_chg   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_lfsr  <= w_lfsr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
      r_valid <= w_valid_nxt;
      r_chg   <= w_chg_nxt;
    end
  end

  assign random_direction = r_dir;
  assign direction_valid  = r_valid;
  assign dir_changed      = r_chg;

endmodule
`default_nettype wire

// File: tb/tb_random_dir_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_random_dir_gen
// Description : Directed bench for random_dir_gen; two instances (4-way and
//               3-way) checked every cycle against an index-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_random_dir_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       resetN, enable, startOfFrame, force_change;
  logic [3:0] blocked_a, dir_a;
  logic       valid_a, chg_a;
  logic [2:0] blocked_b, dir_b;
  logic       valid_b, chg_b;

  int n_checks = 0;
  int n_fail   = 0;
  int picks_b  = 0;

  random_dir_gen #(
    .NUM_DIRS(4), .LFSR_W(8), .TAPS(8'hB8), .SEED(8'h01), .HOLD_FRAMES(3)
  ) u_dut_a (
    .clk(clk), .resetN(resetN), .enable(enable), .startOfFrame(startOfFrame),
    .blocked(blocked_a), .force_change(force_change),
    .random_direction(dir_a), .direction_valid(valid_a), .dir_changed(chg_a)
  );

  random_dir_gen #(
    .NUM_DIRS(3), .LFSR_W(5), .TAPS(5'h12), .SEED(5'h01), .HOLD_FRAMES(2)
  ) u_dut_b (
    .clk(clk), .resetN(resetN), .enable(enable), .startOfFrame(startOfFrame),
    .blocked(blocked_b), .force_change(force_change),
    .random_direction(dir_b), .direction_valid(valid_b), .dir_changed(chg_b)
  );

  localparam int M_IDLE = 0, M_PICK = 1, M_HOLD = 2, M_STUCK = 3;
  typedef struct {int lfsr; int mode; int cnt; int dir; bit chg;} mdl_t;

  // dir is an index (-1 = none); the one-hot form is derived only for compare.
  function automatic mdl_t mreset();
    mdl_t m;
    m.lfsr = 1; m.mode = M_IDLE; m.cnt = 0; m.dir = -1; m.chg = 1'b0;
    return m;
  endfunction

  function automatic int choose(int lfsr, int nd, int blk);
    int c;
    c = lfsr % (1 << $clog2(nd));
    if (c >= nd) c -= nd;
    for (int k = 0; k < nd; k++)
      if (((blk >> ((c + k) % nd)) & 1) == 0) return (c + k) % nd;
    return -1;
  endfunction

  function automatic mdl_t mstep(mdl_t m, int nd, int taps, int hold,
                                 bit en, bit sof, int blk, bit fc);
    mdl_t n;
    int   s;
    n = m;
    n.chg  = 1'b0;
    n.lfsr = (m.lfsr & 1) ? ((m.lfsr >> 1) ^ taps) : (m.lfsr >> 1);
    if (!en) begin
      n.mode = M_IDLE; n.dir = -1; n.cnt = 0;
    end else begin
      case (m.mode)
        M_IDLE: n.mode = M_PICK;
        M_PICK: begin
          s = choose(m.lfsr, nd, blk);
          n.dir = s;
          if (s >= 0) begin
            n.cnt = hold - 1; n.chg = 1'b1; n.mode = M_HOLD;
          end else begin
            n.mode = M_STUCK;
          end
        end
        M_HOLD: begin
          if ((((blk >> m.dir) & 1) == 1) || fc) n.mode = M_PICK;
          else if (sof) begin
            if (m.cnt == 0) n.mode = M_PICK;
            else            n.cnt  = m.cnt - 1;
          end
        end
        default: if (sof) n.mode = M_PICK;
      endcase
    end
    return n;
  endfunction

  function automatic int onehot_of(mdl_t m);
    return (m.dir < 0) ? 0 : (1 << m.dir);
  endfunction

  mdl_t ma, mb;

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      ma = mreset();
      mb = mreset();
    end else begin
      ma = mstep(ma, 4, 'hB8, 3, enable, startOfFrame, int'(blocked_a), force_change);
      mb = mstep(mb, 3, 'h12, 2, enable, startOfFrame, int'(blocked_b), force_change);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("a_dir",   int'(dir_a),   onehot_of(ma));
      chk("a_valid", int'(valid_a), int'(ma.dir >= 0));
      chk("a_chg",   int'(chg_a),   int'(ma.chg));
      chk("b_dir",   int'(dir_b),   onehot_of(mb));
      chk("b_valid", int'(valid_b), int'(mb.dir >= 0));
      chk("b_chg",   int'(chg_b),   int'(mb.chg));
      chk("b_legal", int'(valid_b ? $onehot(dir_b) : (dir_b == 3'b000)), 1);
      if (chg_b) picks_b++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    cyc(1);
    resetN = 1'b1;
  endtask

  logic found;

  initial begin
    resetN = 1'b0; enable = 1'b1; startOfFrame = 1'b0; force_change = 1'b0;
    blocked_a = 4'b0000; blocked_b = 3'b000;
    cyc(2);
    chk("rst_dir",   int'(dir_a),   0);
    chk("rst_valid", int'(valid_a), 0);
    chk("rst_chg",   int'(chg_a),   0);

    // First pick from SEED=1: LFSR is 0xB8 in PICK, so candidate index 0.
    resetN = 1'b1;
    cyc(1);
    chk("t1_pick_not_valid", int'(valid_a), 0);
    cyc(1);
    chk("t1_dir",  int'(dir_a), 4'b0001);
    chk("t1_chg",  int'(chg_a), 1);
    cyc(1);
    chk("t1_chg_pulse", int'(chg_a), 0);
    chk("t1_held",      int'(dir_a), 4'b0001);

    blocked_a = 4'b0001;
    do_reset();
    cyc(2);
    chk("t2_skip_blocked", int'(dir_a), 4'b0010);
    blocked_a = 4'b1111;
    cyc(2);
    chk("t2_stuck_dir",   int'(dir_a),   0);
    chk("t2_stuck_valid", int'(valid_a), 0);
    cyc(2);
    chk("t2_stuck_stays", int'(valid_a), 0);
    blocked_a = 4'b0000;
    startOfFrame = 1'b1;
    cyc(1);
    startOfFrame = 1'b0;
    chk("t2_retry_pick", int'(valid_a), 0);
    cyc(1);
    chk("t2_retry_valid",  int'(valid_a), 1);
    chk("t2_retry_onehot", int'($onehot(dir_a)), 1);

    do_reset();
    cyc(2);
    for (int p = 0; p < 2; p++) begin
      startOfFrame = 1'b1;
      cyc(1);
      startOfFrame = 1'b0;
      cyc(2);
      chk("t3_held", int'(dir_a), 4'b0001);
    end
    startOfFrame = 1'b1;
    cyc(1);
    startOfFrame = 1'b0;
    chk("t3_chg_not_yet", int'(chg_a), 0);
    cyc(1);
    chk("t3_chg_after_expiry", int'(chg_a), 1);

    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (dir_a == 4'b0100) found = 1'b1;
      else begin
        force_change = 1'b1;
        cyc(1);
        force_change = 1'b0;
        cyc(1);
      end
    end
    chk("t4_reach_dir2", int'(found), 1);
    blocked_a = 4'b0100;
    cyc(2);
    chk("t4_avoid_dir2", int'(dir_a == 4'b0100), 0);
    chk("t4_valid",      int'(valid_a), 1);
    chk("t4_chg",        int'(chg_a),   1);
    blocked_a = 4'b0000;
    force_change = 1'b1;
    cyc(1);
    force_change = 1'b0;
    chk("t4_force_not_yet", int'(chg_a), 0);
    cyc(1);
    chk("t4_force_chg", int'(chg_a), 1);

    enable = 1'b0;
    cyc(1);
    chk("t5_dis_dir",   int'(dir_a),   0);
    chk("t5_dis_valid", int'(valid_a), 0);
    enable = 1'b1;
    cyc(2);
    chk("t5_reenable_valid", int'(valid_a), 1);
    cyc(3);
    resetN = 1'b0;
    #1;
    chk("t5_async_dir",   int'(dir_a),   0);
    chk("t5_async_valid", int'(valid_a), 0);
    @(posedge clk);
    #2;
    resetN = 1'b1;
    cyc(2);
    chk("t5_seed_restored", int'(dir_a), 4'b0001);

    picks_b = 0;
    for (int i = 0; i < 4000; i++) begin
      force_change = ($urandom_range(0, 7) != 0);
      startOfFrame = ($urandom_range(0, 7) == 0);
      enable       = ($urandom_range(0, 99) != 0);
      blocked_a    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      blocked_b    = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))  : 3'b000;
      cyc(1);
    end
    chk("t6_b_pick_count", int'(picks_b >= 1000), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/random_dir_gen.md
Name: random_dir_gen

Overview:
Parametrised pseudo-random direction generator for enemies and mines. It replaces the fixed 3-bit-to-4-way decode with four additions:
- an internal LFSR random source;
- a frame-based hold timer;
- avoidance of blocked directions;
- a forced-change request.

It sits between the game-control/collision logic and the object movement controllers, one instance per moving object. It drives a one-hot direction vector.

Parameters:
NUM_DIRS, 4, number of directions (2..8); output is one-hot of this width.
LFSR_W, 8, LFSR width (>= 4).
TAPS, 8'hB8, Galois feedback mask, LFSR_W bits.
SEED, 8'h01, LFSR reset value; a SEED of 0 is replaced by 1.
HOLD_FRAMES, 32, frames a direction is held before re-pick (>= 1).

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
enable  in  1  object active; low forces idle
startOfFrame  in  1  one-cycle frame tick
blocked  in  NUM_DIRS  bit i=1: direction i currently obstructed
force_change  in  1  one-cycle request for an immediate re-pick
random_direction  out  NUM_DIRS  one-hot chosen direction; all-zero when none
direction_valid  out  1  random_direction holds a legal direction
dir_changed  out  1  one-cycle pulse when a new direction is loaded

Behaviour:
Reset (async, resetN=0):
- lfsr=SEED (1 if SEED=0); state=IDLE; hold_cnt=0.
- random_direction=0, direction_valid=0, dir_changed=0.
All registers are clocked on posedge clk.

LFSR:
- Advances every clock in every state.
- Update: if lfsr[0]=1 then lfsr=(lfsr>>1)^TAPS, else lfsr=lfsr>>1.
- It never reaches zero.

Candidate index:
- IDX_W = clog2(NUM_DIRS); c = lfsr[IDX_W-1:0].
- If c >= NUM_DIRS, c = c - NUM_DIRS. One subtraction always suffices.
- The current lfsr value (pre-advance) is used.

Selection:
- Choose the first index in the order c, c+1, ... mod NUM_DIRS whose blocked bit is 0.
- If all bits are blocked, no selection is made.

dir_changed defaults to 0 every cycle (pulse only).

FSM states:
- IDLE: outputs 0. enable=1 -> PICK.
- PICK (one cycle):
  - If a selection exists: random_direction<=onehot(sel), direction_valid<=1, dir_changed<=1, hold_cnt<=HOLD_FRAMES-1, -> HOLD.
  - Otherwise: random_direction<=0, direction_valid<=0, -> STUCK.
- HOLD: evaluated in priority order:
  - blocked[current]=1 or force_change=1 -> PICK.
  - Else if startOfFrame: hold_cnt==0 -> PICK, else hold_cnt-=1.
  - Outputs are held until the PICK cycle rewrites them. The new direction may equal the old one.
- STUCK: outputs 0. startOfFrame -> PICK (retry once per frame).

Global rules:
- enable=0 in any state -> IDLE next edge, with random_direction, direction_valid and hold_cnt cleared. This has the highest priority.
- Reset mid-operation returns everything to the reset values immediately.

Latency:
- enable rise -> valid direction after 2 edges.
- Block/force/expiry event -> new direction after 2 edges (HOLD->PICK, PICK->HOLD).
- A direction is held for exactly HOLD_FRAMES startOfFrame pulses absent other events.

Simultaneous events:
- force_change and startOfFrame in the same cycle: re-pick; hold_cnt is not decremented.
- A force_change pulse in PICK, IDLE or STUCK is ignored.

Test Plan:
1. Defaults, SEED=1, enable=1 from reset release, blocked=0 -> edge1: lfsr=0xB8, PICK; edge2: random_direction=4'b0001, direction_valid=1, dir_changed=1 for one cycle.
2. As test 1 but blocked=4'b0001 -> edge2 gives 4'b0010. With blocked=4'b1111 -> 0000, direction_valid=0, state STUCK. Release blocked=0, then pulse startOfFrame -> valid one-hot 2 edges later.
3. HOLD_FRAMES=3, direction loaded -> output unchanged through 2 startOfFrame pulses. The 3rd pulse causes re-pick, and dir_changed pulses exactly 2 edges after it.
4. In HOLD with direction 4'b0100, assert blocked[2] -> re-pick avoids index 2, so output != 4'b0100. force_change pulse -> dir_changed 2 edges later.
5. enable dropped in HOLD -> next edge random_direction=0, direction_valid=0. resetN pulsed low mid-HOLD -> outputs 0 asynchronously, and lfsr returns to SEED.
6. NUM_DIRS=3, LFSR_W=5, TAPS=5'h12 -> over 1000 picks, output is always one of 001/010/100 and never 000 while direction_valid=1.
